// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operates on magnitudes and fixes up the signs in a single cycle after the iteration.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [5:0]       LAST_IT = 6'(WIDTH-1);

  state_t           state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [5:0]       cnt;
  logic             neg_q, neg_r, sel_rem;

  logic             sign1, sign2, div_zero, div_ovf;
  logic [WIDTH-1:0] a_abs, b_abs, special_res;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    sign1       = ~op[0] & rs1_val[WIDTH-1];
    sign2       = ~op[0] & rs2_val[WIDTH-1];
    a_abs       = sign1 ? -rs1_val : rs1_val;
    b_abs       = sign2 ? -rs2_val : rs2_val;
    div_zero    = (rs2_val == '0);
    div_ovf     = ~op[0] & (rs1_val == MIN_NEG) & (rs2_val == '1);
    // Divide-by-zero and signed overflow results come straight from the operands.
    if (div_zero)
      special_res = op[1] ? rs1_val : '1;
    else
      special_res = op[1] ? '0 : MIN_NEG;
    shifted     = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial       = shifted - {1'b0, dvsr};
    q_fix       = neg_q ? -quo : quo;
    r_fix       = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !kill) begin
            busy    <= 1'b1;
            sel_rem <= op[1];
            if (div_zero || div_ovf) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= special_res;
            end else begin
              state <= CALC;
              rem   <= '0;
              quo   <= a_abs;
              dvsr  <= b_abs;
              neg_q <= sign1 ^ sign2;
              neg_r <= sign1;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            // Borrow out of the WIDTH+1-bit subtract means the trial failed: restore.
            if (!trial[WIDTH]) begin
              rem <= trial;
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted;
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
            if (cnt == LAST_IT) state <= FIX;
          end
        end
        FIX: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state  <= DONE;
            done   <= 1'b1;
            result <= sel_rem ? r_fix : q_fix;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vectors with literal expectations plus a cycle-level
// behavioural model (plain RV32M arithmetic and latency counting) checked every cycle.
module tb_div_unit;

  localparam int W = 32;

  logic         clk, rst_n, start, kill;
  logic [1:0]   op;
  logic [W-1:0] rs1_val, rs2_val;
  logic         busy, done;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M result rules in plain arithmetic.
  function automatic logic [W-1:0] model_res(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    if (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return W + 2;
  endfunction

  // Model: m_cyc is the position inside the current operation (0 = idle).
  int           m_cyc, m_len;
  logic [W-1:0] m_res, m_pend;
  logic         m_busy, m_done;
  assign m_busy = (m_cyc != 0);
  assign m_done = (m_cyc != 0) && (m_cyc == m_len);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_len <= 0; m_res <= '0; m_pend <= '0;
    end else if (m_cyc == 0) begin
      if (start && !kill) begin
        m_cyc  <= 1;
        m_len  <= model_lat(op, rs1_val, rs2_val);
        m_pend <= model_res(op, rs1_val, rs2_val);
        if (model_lat(op, rs1_val, rs2_val) == 1) m_res <= model_res(op, rs1_val, rs2_val);
      end
    end else if (m_cyc == m_len) begin
      m_cyc <= 0;
    end else if (kill) begin
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc + 1 == m_len) m_res <= m_pend;
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (busy !== m_busy || done !== m_done || result !== m_res) begin
        fails++;
        $display("FAIL model_cycle t=%0t busy=%b/%b done=%b/%b result=%h/%h (dut/exp)",
                 $time, busy, m_busy, done, m_done, result, m_res);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Issue one op at cycle 0 and measure the cycle in which done appears.
  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int cyc;
    check({name, "_model"}, model_res(o, a, b), exp);
    @(negedge clk);
    op = o; rs1_val = a; rs2_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; rs1_val = ~a; rs2_val = 32'h1234_5678;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_lat"}, 32'(cyc), 32'(lat));
    check({name, "_res"}, result, exp);
    @(negedge clk);
    check({name, "_idle"}, {31'b0, busy}, 32'h0);
  endtask

  typedef struct {
    string        name;
    logic [1:0]   o;
    logic [W-1:0] a, b, exp;
    int           lat;
  } vec_t;

  vec_t vecs[13] = '{
    '{"divu_100_7",  2'b01, 32'd100,        32'd7,          32'd14,         34},
    '{"remu_100_7",  2'b11, 32'd100,        32'd7,          32'd2,          34},
    '{"div_m20_3",   2'b00, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  34},
    '{"rem_m20_3",   2'b10, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  34},
    '{"rem_20_m3",   2'b10, 32'd20,         32'hFFFF_FFFD,  32'd2,          34},
    '{"divu_5_0",    2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1},
    '{"rem_dead_0",  2'b10, 32'hDEAD_BEEF,  32'd0,          32'hDEAD_BEEF,  1},
    '{"div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
    '{"rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1},
    '{"div_7_m2",    2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34},
    '{"divu_max_1",  2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34},
    '{"div_min_2",   2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  34},
    '{"remu_max_10", 2'b11, 32'hFFFF_FFFF,  32'd10,         32'd5,          34}
  };

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0;
    #12;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Starts at cycles 5 and 34 are ignored; the start in cycle 35 completes in cycle 69.
    ndone = 0;
    for (int c = 0; c <= 72; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (c == 34) check("busy_first_res", result, 32'd333);
        else if (c == 69) check("busy_second_res", result, 32'd50);
        else check("busy_done_cycle", 32'(c), 32'd34);
      end
      start = (c == 0 || c == 5 || c == 34 || c == 35);
      op = 2'b01;
      rs1_val = (c == 35) ? 32'd500 : (c == 0) ? 32'd1000 : 32'd9;
      rs2_val = (c == 35) ? 32'd10  : (c == 0) ? 32'd3    : 32'd2;
    end
    start = 1'b0;
    check("busy_done_count", 32'(ndone), 32'd2);

    // Kill in IDLE together with start: request dropped.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 2'b01; rs1_val = 32'd77; rs2_val = 32'd7;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_idle_busy", {31'b0, busy}, 32'h0);

    // Kill at cycle 10: idle in cycle 11, result keeps the prior value (50).
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 11) begin
        check("kill_calc_busy", {31'b0, busy}, 32'h0);
        check("kill_calc_res", result, 32'd50);
      end
      start = (c == 0);
      kill  = (c == 10);
      op = 2'b01; rs1_val = 32'd999; rs2_val = 32'd9;
    end

    // Kill in FIX (cycle 33) also aborts; kill in DONE (cycle 34) does not.
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 34) check("kill_fix_done", {31'b0, done}, 32'h0);
      start = (c == 0);
      kill  = (c == 33);
      op = 2'b01; rs1_val = 32'd999; rs2_val = 32'd9;
    end
    kill = 1'b0;
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      if (c == 34) begin
        check("kill_done_pulse", {31'b0, done}, 32'h1);
        check("kill_done_res", result, 32'd111);
      end
      start = (c == 0);
      kill  = (c == 34);
      op = 2'b01; rs1_val = 32'd999; rs2_val = 32'd9;
    end
    kill = 1'b0;

    // Asynchronous reset in cycle 20 of an operation.
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      start = (c == 0);
      op = 2'b11; rs1_val = 32'd1000; rs2_val = 32'd7;
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 2'b11, 32'd1000, 32'd7, 32'd6, 34);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
